pattern_tx_10010: RTL and testbench

//  Serial pattern transmitter: the stimulus/driver end of the 10010 sequence-detection link.
//  On a start pulse, shifts out a PAT_LEN-bit pattern MSB-first on a one-bit serial line.

---
 rtl/pattern_tx_10010_if.sv | 31 +++
 rtl/pattern_tx_10010.sv | 130 +++++++++++++
 tb/tb_pattern_tx_10010.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pattern_tx_10010_if.sv
// Request/serial-stream bundle of the 10010 pattern transmitter.
// The requester (master) drives start/repeat_num; the transmitter (slave)
// drives the serial bit and its status flags.
interface pattern_tx_10010_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] repeat_num;
    logic             data_out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output repeat_num,
        input  data_out,
        input  valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  repeat_num,
        output data_out,
        output valid,
        output busy,
        output done
    );
endinterface

// File: rtl/pattern_tx_10010.sv
// Serial pattern transmitter: on an accepted start, shifts PATTERN out
// MSB-first repeat_num times, with GAP zero bits between repeats, then
// pulses done for one cycle. All outputs are registered and decoded from
// the next state, so the first bit appears the cycle after acceptance.
module pattern_tx_10010 #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
    parameter int                 GAP     = 2,
    parameter int                 CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pattern_tx_10010_if.slave    bus
);

    localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_q,    state_d;
    logic [IDX_W-1:0] bit_idx_q,  bit_idx_d;
    logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic             data_out_q, data_out_d;
    logic             valid_q,    valid_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    // Next-state, counter and output decode for the transmit sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.repeat_num != '0) begin
                        state_d   = ST_SEND;
                        rep_cnt_d = bus.repeat_num;
                        bit_idx_d = IDX_LAST;
                    end else begin
                        // Zero-length request: acknowledge without sending.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (bit_idx_q == '0) begin
                    // End of one repeat.
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    if (rep_cnt_q > CNT_W'(1)) begin
                        if (GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LAST;
                        end else begin
                            bit_idx_d = IDX_LAST;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = ST_SEND;
                    bit_idx_d = IDX_LAST;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered, so they can be registered
        // without adding a cycle of latency.
        valid_d    = (state_d == ST_SEND);
        data_out_d = valid_d & PATTERN[bit_idx_d];
        busy_d     = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d     = (state_d == ST_DONE);
    end

    // State, counters and registered outputs; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            rep_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            data_out_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            rep_cnt_q  <= rep_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_pattern_tx_10010.sv
// Bench for pattern_tx_10010: a directed table, a reset-abort sequence,
// loopback detection of 10010 and randomized transfers, all compared
// cycle by cycle against a stream model built from the transfer rules.
module tb_pattern_tx_10010;

    localparam int             PAT_LEN = 5;
    localparam logic [4:0]     PATTERN = 5'b10010;
    localparam int             GAP     = 2;
    localparam int             CNT_W   = 8;

    // Observed/expected per cycle: {data_out, valid, busy, done}.
    typedef logic [3:0] obs_t;

    typedef struct {
        int n;
        int repulse;
        int exp_busy;
        int exp_valid;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pattern_tx_10010_if #(.CNT_W(CNT_W)) bus  ();
    pattern_tx_10010_if #(.CNT_W(CNT_W)) bus0 ();

    pattern_tx_10010 #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .GAP     (GAP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Second instance with back-to-back repeats.
    pattern_tx_10010 #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .GAP     (0),
        .CNT_W   (CNT_W)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got data/valid/busy/done=%b, expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference stream: N copies of the pattern MSB-first separated by gap
    // zero cycles, then a single done cycle.
    function automatic void build_expected(input int n, input int gap, output obs_t q[$]);
        logic [4:0] pat;
        pat = PATTERN;
        q = {};
        for (int r = 0; r < n; r++) begin
            for (int b = PAT_LEN - 1; b >= 0; b--) q.push_back({pat[b], 3'b110});
            if (r < n - 1) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
        end
        q.push_back(4'b0001);
    endfunction

    function automatic obs_t get_obs(input bit sel);
        if (sel) return {bus0.data_out, bus0.valid, bus0.busy, bus0.done};
        return {bus.data_out, bus.valid, bus.busy, bus.done};
    endfunction

    task automatic drive(input bit sel, input logic s, input logic [CNT_W-1:0] n);
        if (sel) begin
            bus0.start      = s;
            bus0.repeat_num = n;
        end else begin
            bus.start       = s;
            bus.repeat_num  = n;
        end
    endtask

    // Issue one request and follow it for its full expected length plus two
    // idle cycles. repulse>0 raises start again during that cycle.
    task automatic run_transfer(input string name, input bit sel, input int n, input int repulse,
                                output int busy_cnt, output int valid_cnt, output int done_cyc,
                                output int hits);
        obs_t       exp_q[$];
        obs_t       o;
        logic [4:0] hist;
        hist = '0;
        busy_cnt = 0;
        valid_cnt = 0;
        done_cyc = 0;
        hits = 0;
        build_expected(n, sel ? 0 : GAP, exp_q);
        @(negedge clk);
        drive(sel, 1'b1, CNT_W'(n));
        for (int i = 0; i < exp_q.size() + 2; i++) begin
            @(negedge clk);
            o = get_obs(sel);
            drive(sel, (i + 1) == repulse, CNT_W'($urandom));
            check(name, i + 1, o, (i < exp_q.size()) ? exp_q[i] : 4'b0000);
            if (o[1]) busy_cnt++;
            if (o[2]) valid_cnt++;
            if (o[0]) done_cyc = i + 1;
            hist = {hist[3:0], o[3]};
            if (hist == 5'b10010) hits++;
        end
        drive(sel, 1'b0, '0);
    endtask

    initial begin
        vec_t tbl[6];
        int   busy_cnt, valid_cnt, done_cyc, hits;
        int   n, sel, len, rp, g;

        tbl[0] = '{n: 1, repulse: 0, exp_busy: 5,  exp_valid: 5,  exp_done: 6};
        tbl[1] = '{n: 3, repulse: 0, exp_busy: 19, exp_valid: 15, exp_done: 20};
        tbl[2] = '{n: 0, repulse: 0, exp_busy: 0,  exp_valid: 0,  exp_done: 1};
        tbl[3] = '{n: 1, repulse: 3, exp_busy: 5,  exp_valid: 5,  exp_done: 6};
        tbl[4] = '{n: 2, repulse: 13, exp_busy: 12, exp_valid: 10, exp_done: 13};
        tbl[5] = '{n: 4, repulse: 0, exp_busy: 26, exp_valid: 20, exp_done: 27};

        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (2) @(negedge clk);
        check("reset_state", 0, get_obs(0), 4'b0000);
        check("reset_state_gap0", 0, get_obs(1), 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int t = 0; t < 6; t++) begin
            run_transfer($sformatf("table%0d", t), 0, tbl[t].n, tbl[t].repulse,
                         busy_cnt, valid_cnt, done_cyc, hits);
            check_int($sformatf("table%0d_busy", t),  busy_cnt,  tbl[t].exp_busy);
            check_int($sformatf("table%0d_valid", t), valid_cnt, tbl[t].exp_valid);
            check_int($sformatf("table%0d_done", t),  done_cyc,  tbl[t].exp_done);
        end

        // Reset in cycle 3 of a 3-repeat transfer: immediate abort, no done.
        @(negedge clk);
        drive(0, 1'b1, 8'd3);
        @(negedge clk);
        drive(0, 1'b0, '0);
        check("abort_c1", 1, get_obs(0), 4'b1110);
        @(negedge clk);
        @(negedge clk);
        check("abort_c3", 3, get_obs(0), 4'b0110);
        #2 rst_n = 1'b0;
        #1 check("abort_now", 3, get_obs(0), 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_hold", 4 + i, get_obs(0), 4'b0000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", i, get_obs(0), 4'b0000);
        end
        run_transfer("after_reset", 0, 1, 0, busy_cnt, valid_cnt, done_cyc, hits);
        check_int("after_reset_done", done_cyc, 6);

        // Loopback into a 10010 detector, with and without gaps.
        run_transfer("loop_gap2", 0, 4, 0, busy_cnt, valid_cnt, done_cyc, hits);
        check_int("loop_gap2_hits", hits, 4);
        run_transfer("loop_gap0", 1, 4, 0, busy_cnt, valid_cnt, done_cyc, hits);
        check_int("loop_gap0_hits", hits, 4);
        check_int("loop_gap0_busy", busy_cnt, 20);

        // Randomized transfers on either instance.
        for (int k = 0; k < 16; k++) begin
            n   = $urandom_range(0, 6);
            sel = $urandom_range(0, 1);
            g   = (sel != 0) ? 0 : GAP;
            len = (n == 0) ? 1 : n * PAT_LEN + (n - 1) * g + 1;
            rp  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, len) : 0;
            run_transfer($sformatf("rand%0d", k), sel[0], n, rp, busy_cnt, valid_cnt, done_cyc, hits);
            check_int($sformatf("rand%0d_busy", k), busy_cnt, len - 1);
            check_int($sformatf("rand%0d_hits", k), hits, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
